// File: rtl/csa_accum_ctrl_if.sv
// Operand and result valid/ready streams of the carry-save accumulator.
interface csa_accum_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic                    op_valid;
  logic                    op_ready;
  logic [DATA_W-1:0]       op_data;
  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_W+CNT_W-1:0] res_data;

  modport master (
    output op_valid, op_data, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_data, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: one 3:2 carry-save stage per accepted operand,
// single carry-propagate add once the burst is complete.
module csa_accum_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  output logic               busy,
  csa_accum_ctrl_if.slave    acc
);

  localparam int RES_W = DATA_W + CNT_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state_q;
  logic [RES_W-1:0] sum_q;
  logic [RES_W-1:0] carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RES_W-1:0] res_q;

  logic [RES_W-1:0] x;
  logic [RES_W-1:0] maj;
  logic [RES_W-1:0] csa_sum;
  logic [RES_W-1:0] csa_carry;

  // 3:2 compression of the redundant pair with the zero-extended operand
  always_comb begin
    x         = RES_W'(acc.op_data);
    csa_sum   = sum_q ^ carry_q ^ x;
    maj       = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);
    csa_carry = {maj[RES_W-2:0], 1'b0};
  end

  // Burst sequencing and redundant-sum state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= len;
            state_q <= (len != '0) ? S_ACCUM : S_RESOLVE;
          end
        end
        S_ACCUM: begin
          // op_ready is implied by the state, so op_valid alone is the accept
          if (acc.op_valid) begin
            sum_q   <= csa_sum;
            carry_q <= csa_carry;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= S_RESOLVE;
            end
          end
        end
        S_RESOLVE: begin
          res_q   <= sum_q + carry_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (acc.res_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode from the state register only
  always_comb begin
    acc.op_ready  = (state_q == S_ACCUM);
    acc.res_valid = (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
    acc.res_data  = res_q;
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl with a result scoreboard.
module tb_csa_accum_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;

  csa_accum_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  csa_accum_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .busy  (busy),
    .acc   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_q[$];
  int unsigned ops[16];
  int unsigned gaps[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // wait for the result, compare against the scoreboard, then handshake
  task automatic get_result(input int stall, input bit poke);
    int lat;
    int unsigned exp;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      chk("no_op_ready_before_result", {31'd0, bus.op_ready}, 32'd0);
      cycle();
      lat++;
    end
    chk("res_valid_seen", {31'd0, bus.res_valid}, 32'd1);
    // last accept (or start for len=0) at edge t, visible at edge t+2
    chk("result_latency_edges", 32'(lat + 1), 32'd2);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("res_data", {20'd0, bus.res_data}, exp);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        start = 1'b1;
        len   = 4'd3;
      end
      cycle();
      start = 1'b0;
      chk("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("stall_res_data", {20'd0, bus.res_data}, exp);
    end
    bus.res_ready = 1'b1;
    if (poke) start = 1'b1;
    cycle();
    start = 1'b0;
    chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
    chk("busy_drop", {31'd0, busy}, 32'd0);
    cycle();
    chk("stays_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_burst(input int n, input int stall, input bit poke);
    int unsigned s;
    int unsigned accepts;
    s = 0;
    accepts = 0;
    bus.res_ready = (stall == 0);
    for (int i = 0; i < n; i++) s += ops[i];
    exp_q.push_back(s);
    start = 1'b1;
    len   = CNT_W'(n);
    cycle();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < int'(gaps[i]); g++) begin
        if (poke) begin
          start = 1'b1;
          len   = 4'd1;
        end
        cycle();
        start = 1'b0;
        chk("gap_op_ready", {31'd0, bus.op_ready}, 32'd1);
      end
      chk("op_ready", {31'd0, bus.op_ready}, 32'd1);
      bus.op_valid = 1'b1;
      bus.op_data  = DATA_W'(ops[i]);
      cycle();
      bus.op_valid = 1'b0;
      accepts++;
    end
    chk("accept_count", accepts, 32'(n));
    chk("op_ready_after_burst", {31'd0, bus.op_ready}, 32'd0);
    get_result(stall, poke);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    bus.op_valid = 1'b0;
    bus.op_data = '0;
    bus.res_ready = 1'b1;
    #1;
    chk("rst_op_ready", {31'd0, bus.op_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_data", {20'd0, bus.res_data}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // three operands back-to-back
    ops[0] = 5; ops[1] = 7; ops[2] = 9;
    gaps[0] = 0; gaps[1] = 0; gaps[2] = 0;
    run_burst(3, 0, 1'b0);

    // maximum burst of maximum operands
    for (int i = 0; i < 15; i++) begin
      ops[i]  = 255;
      gaps[i] = 0;
    end
    run_burst(15, 0, 1'b0);

    // valid gaps and result back-pressure
    ops[0] = 1; ops[1] = 2; ops[2] = 3; ops[3] = 4;
    gaps[0] = 0; gaps[1] = 1; gaps[2] = 2; gaps[3] = 3;
    run_burst(4, 5, 1'b0);

    // empty burst
    run_burst(0, 0, 1'b0);

    // start pulsed during ACCUM gaps and during DONE
    ops[0] = 10; ops[1] = 20;
    gaps[0] = 2; gaps[1] = 1;
    run_burst(2, 2, 1'b1);

    // start with op_valid in IDLE consumes nothing; start with an accept is ignored
    exp_q.push_back(7);
    bus.res_ready = 1'b1;
    start = 1'b1;
    len = 4'd2;
    bus.op_valid = 1'b1;
    bus.op_data = 8'd50;
    cycle();
    start = 1'b0;
    chk("idle_valid_busy", {31'd0, busy}, 32'd1);
    chk("idle_valid_op_ready", {31'd0, bus.op_ready}, 32'd1);
    bus.op_data = 8'd3;
    cycle();
    start = 1'b1;
    len = 4'd9;
    bus.op_data = 8'd4;
    cycle();
    start = 1'b0;
    bus.op_valid = 1'b0;
    get_result(0, 1'b0);

    // asynchronous reset in the middle of a burst
    start = 1'b1;
    len = 4'd5;
    cycle();
    start = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_data = 8'd100;
    cycle();
    cycle();
    bus.op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_op_ready", {31'd0, bus.op_ready}, 32'd0);
    chk("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res_data", {20'd0, bus.res_data}, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    ops[0] = 1; ops[1] = 2;
    gaps[0] = 0; gaps[1] = 0;
    run_burst(2, 0, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
- Sequential multi-operand accumulator built around a 3:2 carry-save compressor.
- After a start command it accepts a burst of `len` operands over a valid/ready stream. Each accepted operand is folded into redundant sum/carry registers: one CSA stage per cycle, with no carry propagation in the loop.
- After the burst, it does one carry-propagate add and presents the result on a valid/ready output port.
- Used wherever a data path must sum a variable-length operand stream at one operand per cycle.

Parameters:
- DATA_W, 8, width of each input operand.
- CNT_W, 4, width of `len` and of the remaining-operand counter. Maximum burst is 2^CNT_W-1 operands.
- RES_W (derived, DATA_W+CNT_W), result width. It holds the worst-case sum (2^CNT_W-1)*(2^DATA_W-1) without overflow.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a burst. Sampled only in IDLE.
- len  in  CNT_W  number of operands in the burst. Sampled with start.
- op_valid  in  1  operand valid.
- op_ready  out  1  operand ready.
- op_data  in  DATA_W  operand, unsigned.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  RES_W  sum of the burst, unsigned.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset (asynchronous, any state, including mid-burst):
  - State goes to IDLE.
  - sum_q, carry_q, cnt_q and res_data go to 0.
  - op_ready=0, res_valid=0, busy=0.
  - No partial result survives reset.
- Output decoding: op_ready, res_valid and busy decode from the state register only. There is no combinational path from any input to any output.
- IDLE:
  - op_ready=0, busy=0.
  - On start=1: sum_q<=0, carry_q<=0, cnt_q<=len.
  - Next state is ACCUM if len!=0, else RESOLVE.
  - op_valid in IDLE is ignored and no operand is consumed, even in the same cycle as start.
- ACCUM:
  - op_ready=1.
  - An operand is accepted when op_valid&op_ready. x is op_data zero-extended to RES_W. On accept:
    - sum_q <= sum_q^carry_q^x.
    - carry_q <= (majority(sum_q,carry_q,x))<<1, truncated to RES_W.
    - cnt_q <= cnt_q-1.
  - Cycles with op_valid=0 leave all registers unchanged. There is no timeout.
  - Accept with cnt_q==1 moves to RESOLVE.
  - start is ignored.
- RESOLVE (exactly 1 cycle):
  - res_data <= sum_q+carry_q, modulo 2^RES_W (never wraps, by the RES_W sizing).
  - Next state is DONE.
- DONE:
  - res_valid=1.
  - res_data is held stable until the handshake.
  - On res_ready=1, go to IDLE. A start asserted in that same cycle is ignored.
  - start and op_valid are ignored.
- Latency: last operand accepted at edge t -> res_valid high from edge t+2. For len=0, start at edge t -> res_valid from edge t+2.
- Throughput: len+3 cycles per burst minimum (start, len accepts, resolve, result handshake).
- Back-pressure: res_ready low holds DONE indefinitely.
- Spurious inputs: res_ready high outside DONE has no effect.

Test Plan:
1. len=3, operands 5, 7, 9 back-to-back, res_ready=1 → res_data=21. res_valid is high for exactly one cycle, 2 cycles after the third accept. busy then drops.
2. DATA_W=8, CNT_W=4, len=15, all operands 255 → res_data=3825 (0xEF1), no overflow. op_ready is high for exactly 15 accepted transfers.
3. len=4, operands 1, 2, 3, 4 with op_valid gaps of 0-3 cycles, and res_ready held low 5 cycles after res_valid → counter advances only on accepts. res_data=10, held stable through the stall, then IDLE.
4. len=0 → res_data=0 with res_valid 2 cycles after start. op_ready never asserts.
5. start pulsed during ACCUM and during DONE → ignored, result unaffected. start together with op_valid in IDLE → that operand is not consumed.
6. rst_n low for 1 cycle after 2 of 5 operands (values 100, 100) → all outputs 0 immediately. A following burst len=2, operands 1, 2 gives res_data=3, with no residue from the aborted burst.
